// File: rtl/rule_scheduler.sv
// Rule scheduler for the generated protocol model: issues one enabled rule index per
// cycle (round-robin or LFSR-seeded search) and flags a sticky global deadlock.
module rule_scheduler #(
  parameter int unsigned NUM_RULES    = 104,
  parameter int unsigned IDX_W        = 7,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned DEAD_CYCLES  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 mode_i,
  input  logic [NUM_RULES-1:0] guard_i,
  input  logic                 stall_i,
  output logic [IDX_W-1:0]     en_a_o,
  output logic                 fire_o,
  output logic                 deadlock_o,
  output logic                 forced_o,
  output logic [15:0]          issue_cnt_o
);

  localparam int unsigned      SW   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned      DW   = $clog2(DEAD_CYCLES + 1);
  localparam logic [IDX_W:0]   NR   = (IDX_W + 1)'(NUM_RULES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_RULES - 1);

  typedef enum logic [1:0] {OFF, RUN, DEAD} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [SW-1:0]    starve_cnt;
  logic [DW-1:0]    dead_cnt;

  logic                 no_guard;
  logic                 dead_hit;
  logic                 force_rr;
  logic                 use_rr;
  logic [IDX_W-1:0]     rr_start;
  logic [IDX_W-1:0]     rnd_start;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     off;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W:0]       rnd_wide;
  logic [IDX_W:0]       sum;
  logic [NUM_RULES-1:0] rot;

  always_comb begin
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    no_guard  = (guard_i == '0);
    dead_hit  = no_guard && !stall_i && (dead_cnt == DW'(DEAD_CYCLES - 1));
    force_rr  = mode_i && (starve_cnt == SW'(STARVE_LIMIT));
    use_rr    = !mode_i || force_rr;
    rr_start  = (ptr == LAST) ? '0 : ptr + 1'b1;
    rnd_wide  = {1'b0, lfsr[IDX_W-1:0]};
    rnd_start = IDX_W'((rnd_wide >= NR) ? rnd_wide - NR : rnd_wide);
    start     = use_rr ? rr_start : rnd_start;
    // Rotate the guards so the start index sits at bit 0; the lowest set bit is
    // then the wrap-around distance to the chosen rule.
    rot = NUM_RULES'({guard_i, guard_i} >> start);
    off = '0;
    for (int unsigned j = 0; j < NUM_RULES; j++) begin
      if (rot[NUM_RULES-1-j]) off = IDX_W'(NUM_RULES - 1 - j);
    end
    sum = {1'b0, start} + {1'b0, off};
    sel = IDX_W'((sum >= NR) ? sum - NR : sum);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= OFF;
      ptr         <= LAST;
      lfsr        <= LFSR_SEED;
      starve_cnt  <= '0;
      dead_cnt    <= '0;
      en_a_o      <= '0;
      fire_o      <= 1'b0;
      deadlock_o  <= 1'b0;
      forced_o    <= 1'b0;
      issue_cnt_o <= '0;
    end else begin
      if (fire_o && !stall_i && issue_cnt_o != '1) issue_cnt_o <= issue_cnt_o + 1'b1;
      case (state)
        OFF: begin
          fire_o   <= 1'b0;
          forced_o <= 1'b0;
          if (enable_i) state <= RUN;
        end
        RUN: begin
          if (!stall_i) begin
            lfsr     <= lfsr_next;
            dead_cnt <= no_guard ? dead_cnt + 1'b1 : '0;
          end
          if (dead_hit) begin
            state      <= DEAD;
            deadlock_o <= 1'b1;
            fire_o     <= 1'b0;
            forced_o   <= 1'b0;
          end else if (!enable_i) begin
            state    <= OFF;
            fire_o   <= 1'b0;
            forced_o <= 1'b0;
          end else if (!stall_i) begin
            if (no_guard) begin
              fire_o   <= 1'b0;
              forced_o <= 1'b0;
            end else begin
              en_a_o   <= sel;
              fire_o   <= 1'b1;
              forced_o <= force_rr;
              ptr      <= sel;
              if (use_rr) starve_cnt <= '0;
              else        starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        DEAD: begin
          fire_o     <= 1'b0;
          forced_o   <= 1'b0;
          deadlock_o <= 1'b1;
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_rule_scheduler.sv
// Scoreboard bench for rule_scheduler: stimulus pushes model predictions, a monitor
// pops one prediction per clock and compares all outputs.
module tb_rule_scheduler;

  localparam int NR = 104;

  typedef struct packed {
    logic        fire;
    logic [6:0]  en_a;
    logic        forced;
    logic        dl;
    logic [15:0] cnt;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [NR-1:0] guard_i = '0;
  logic [6:0]    en_a_o;
  logic          fire_o;
  logic          deadlock_o;
  logic          forced_o;
  logic [15:0]   issue_cnt_o;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  exp_t mon_e;
  exp_t mon_a;

  // reference model state
  int          m_st;  // 0 off, 1 run, 2 dead
  int          m_ptr;
  int          m_starve;
  int          m_dead;
  int          m_cnt;
  int unsigned m_lfsr;
  bit          m_fire;
  bit          m_forced;
  bit          m_dl;
  logic [6:0]  m_en_a;

  always #5 clock = ~clock;

  rule_scheduler #(
    .NUM_RULES(104),
    .IDX_W(7),
    .LFSR_SEED(16'hACE1),
    .STARVE_LIMIT(15),
    .DEAD_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable_i(enable_i),
    .mode_i(mode_i),
    .guard_i(guard_i),
    .stall_i(stall_i),
    .en_a_o(en_a_o),
    .fire_o(fire_o),
    .deadlock_o(deadlock_o),
    .forced_o(forced_o),
    .issue_cnt_o(issue_cnt_o)
  );

  function automatic int pick(input logic [NR-1:0] g, input int s);
    for (int k = 0; k < NR; k++) if (g[(s + k) % NR]) return (s + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ptr = NR - 1; m_starve = 0; m_dead = 0; m_cnt = 0;
    m_lfsr = 32'hACE1; m_fire = 0; m_forced = 0; m_dl = 0; m_en_a = '0;
  endtask

  task automatic model(input bit en, input bit md, input logic [NR-1:0] g, input bit st);
    bit none;
    bit frc;
    int s;
    int r;
    int unsigned fb;
    none = (g == '0);
    if (m_fire && !st && m_cnt < 65535) m_cnt++;
    if (m_st == 0) begin
      if (en) m_st = 1;
    end else if (m_st == 1) begin
      if (!st && none && m_dead + 1 >= 8) begin
        m_st = 2; m_dl = 1; m_fire = 0; m_forced = 0;
      end else begin
        if (!st) m_dead = none ? m_dead + 1 : 0;
        if (!en) begin
          m_st = 0; m_fire = 0; m_forced = 0;
        end else if (!st) begin
          if (none) begin
            m_fire = 0; m_forced = 0;
          end else begin
            frc = md && (m_starve == 15);
            s = (!md || frc) ? (m_ptr + 1) % NR : int'(m_lfsr % 128) % NR;
            r = pick(g, s);
            m_en_a = 7'(r); m_fire = 1; m_forced = frc; m_ptr = r;
            m_starve = (md && !frc) ? m_starve + 1 : 0;
          end
        end
      end
      if (!st) begin
        fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 15);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step(input bit en, input bit md, input logic [NR-1:0] g, input bit st);
    exp_t e;
    @(negedge clock);
    enable_i = en; mode_i = md; guard_i = g; stall_i = st;
    model(en, md, g, st);
    e = {m_fire, m_en_a, m_forced, m_dl, 16'(m_cnt)};
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; enable_i = 0; mode_i = 0; stall_i = 0; guard_i = '0;
    model_reset();
    #1;
    check("reset_outputs", {7'd0, fire_o, en_a_o, forced_o, deadlock_o, issue_cnt_o}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [NR-1:0] rand_guard();
    logic [127:0] w;
    logic [127:0] m;
    int kind;
    kind = $urandom_range(0, 9);
    w = {$urandom, $urandom, $urandom, $urandom};
    m = {$urandom, $urandom, $urandom, $urandom};
    if (kind == 0) return '0;
    if (kind == 1) begin
      w = '0;
      w[$urandom_range(0, NR - 1)] = 1'b1;
      return w[NR-1:0];
    end
    if (kind < 6) w = w & m & {$urandom, $urandom, $urandom, $urandom};
    return w[NR-1:0];
  endfunction

  // monitor: one prediction is consumed per clock edge that followed a stimulus step
  initial forever begin
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = {fire_o, en_a_o, forced_o, deadlock_o, issue_cnt_o};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL out @%0t: got fire=%0b en_a=%0d forced=%0b dl=%0b cnt=%0d required fire=%0b en_a=%0d forced=%0b dl=%0b cnt=%0d",
                 $time, mon_a.fire, mon_a.en_a, mon_a.forced, mon_a.dl, mon_a.cnt,
                 mon_e.fire, mon_e.en_a, mon_e.forced, mon_e.dl, mon_e.cnt);
      end
    end
  end

  initial begin
    logic [NR-1:0] g_a;
    logic [NR-1:0] g_b;
    logic [NR-1:0] ones;
    logic [NR-1:0] one_bit;
    bit md;
    g_a = '0; g_a[0] = 1'b1; g_a[5] = 1'b1; g_a[9] = 1'b1;
    g_b = '0; g_b[103] = 1'b1; g_b[2] = 1'b1;
    ones = '1;
    one_bit = '0; one_bit[37] = 1'b1;

    do_reset();
    repeat (7) step(1, 0, g_a, 0);
    repeat (6) step(1, 0, g_b, 0);

    do_reset();
    repeat (45) step(1, 1, ones, 0);

    repeat (2) step(1, 0, g_a, 0);
    repeat (3) step(1, 0, g_a, 1);
    repeat (3) step(1, 0, g_a, 0);
    repeat (2) step(1, 1, ones, 0);
    repeat (3) step(1, 1, ones, 1);
    repeat (3) step(1, 1, ones, 0);
    repeat (20) step(1, 1, one_bit, 0);
    step(0, 0, g_a, 0);
    repeat (3) step(1, 0, g_a, 0);

    md = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) md = ~md;
      step($urandom_range(0, 19) != 0, md, rand_guard(), $urandom_range(0, 3) == 0);
    end

    do_reset();
    repeat (3) step(1, 0, g_a, 0);
    repeat (8) step(1, 0, '0, 0);
    step(1, 0, g_a, 0);
    step(0, 0, g_a, 0);
    step(1, 1, ones, 0);
    step(1, 0, g_a, 0);
    @(posedge clock); #1;
    check("deadlock_sticky", {30'd0, deadlock_o, fire_o}, 32'h2);
    do_reset();

    repeat (65545) step(1, 0, one_bit, 0);
    repeat (2) step(1, 0, one_bit, 1);
    step(1, 0, one_bit, 0);
    @(posedge clock); #1;
    check("cnt_saturated", {16'd0, issue_cnt_o}, 32'hFFFF);

    @(negedge clock);
    check("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rule_scheduler.md
Name: rule_scheduler

Overview:
- Drives the rule-select input `io_en_a` of the generated protocol `system` model (clients, channels 1/2_4/3, home directory).
- Each cycle, picks one rule whose guard is true and issues its index with a qualifying `fire_o` strobe.
- Supports fair round-robin and seeded pseudo-random exploration.
- Detects global deadlock: no rule enabled for a programmable number of cycles.

Parameters:
- NUM_RULES, 104, number of rules (guard vector width); must satisfy NUM_RULES <= 2^IDX_W < 2*NUM_RULES.
- IDX_W, 7, width of the rule index (matches io_en_a).
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be non-zero.
- STARVE_LIMIT, 15, consecutive random-mode issues before one forced round-robin issue.
- DEAD_CYCLES, 8, consecutive all-zero-guard cycles that declare deadlock.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-low
- enable_i  in  1  scheduler run enable
- mode_i  in  1  0 = round-robin, 1 = pseudo-random
- guard_i  in  NUM_RULES  bit r = guard of rule r true this cycle
- stall_i  in  1  system not ready; hold the current issue
- en_a_o  out  IDX_W  selected rule index, connects to io_en_a
- fire_o  out  1  en_a_o valid this cycle
- deadlock_o  out  1  sticky deadlock flag
- forced_o  out  1  current issue is a forced round-robin pick
- issue_cnt_o  out  16  number of issued rules, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - en_a_o=0, fire_o=0, deadlock_o=0, forced_o=0, issue_cnt_o=0.
  - RR pointer = NUM_RULES-1, so the first RR search starts at rule 0.
  - LFSR=LFSR_SEED; starve and dead counters = 0; state OFF.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, x^16+x^14+x^13+x^11+1. Advances every cycle in RUN when stall_i=0.
- States:
  - OFF: outputs quiescent (fire_o=0). Go to RUN when enable_i=1.
  - RUN: issues rules. Go to OFF when enable_i=0; fire_o drops the next cycle.
  - DEAD: fire_o=0, deadlock_o=1. Left only by reset; enable_i is ignored.
- Selection (in RUN, stall_i=0, guard_i != 0):
  - Start index:
    - RR mode: ptr+1, wrapping NUM_RULES-1 -> 0.
    - Random mode: s = LFSR[IDX_W-1:0]; if s >= NUM_RULES, s -= NUM_RULES.
  - Search upward from the start index with wrap-around; take the first r with guard_i[r]=1.
  - Result is registered: en_a_o=r and fire_o=1 in the cycle after guard_i is sampled (latency 1).
  - ptr <= r after every issue, in both modes.
- Starvation:
  - In random mode, count consecutive issues.
  - When the count reaches STARVE_LIMIT, the next issue uses the RR start index, forced_o=1 for that issue, and the count clears.
  - RR-mode issues hold the count at 0.
- Stall: while stall_i=1:
  - en_a_o and fire_o hold their values; nothing advances (ptr, LFSR, counters).
  - The dead counter neither increments nor clears.
  - guard_i is resampled when stall_i falls.
- No guard (guard_i=0 in RUN, stall_i=0):
  - fire_o=0 next cycle; en_a_o holds its last value.
  - The dead counter increments; it reaching DEAD_CYCLES -> DEAD.
  - Any cycle with a non-zero guard_i clears the dead counter.
- issue_cnt_o: +1 per cycle with fire_o=1 and stall_i=0; saturates at 16'hFFFF.
- Simultaneous events:
  - enable_i=0 together with a valid guard: no issue.
  - DEAD entry takes priority over enable_i.
  - Reset mid-issue clears everything immediately, with no completion.
- Single guard bit set: that rule is issued every cycle in either mode.

Test Plan:
- Reset with reset=0, then reset=1, enable_i=1, mode_i=0, guard_i bits {0,5,9} set constant -> en_a_o sequence 0,5,9,0,5; fire_o=1 from the 2nd cycle after enable.
- RR wrap: guard_i bits {103,2} -> en_a_o 2,103,2,103; ptr wraps 103->0 correctly.
- Random mode, all guards 1, seed 16'hACE1 -> en_a_o matches the reference LFSR model (s=LFSR[6:0], minus 104 if >=104); forced_o=1 exactly on issues 16, 32, ..., and each forced index equals ptr+1.
- Stall: assert stall_i for 3 cycles mid-run -> en_a_o/fire_o frozen; issue_cnt_o unchanged; the next index after release equals what the search would have chosen before the stall.
- Deadlock: guard_i=0 for 8 cycles -> deadlock_o=1 on cycle 9, fire_o=0; restoring guards and toggling enable_i has no effect; reset=0 clears it.
- Counter saturation: force issue_cnt_o to 16'hFFFE and issue 3 rules -> reads 16'hFFFF and stays there.
